multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Second-generation main control FSM for the multi-cycle RV32I core, replacing the fixed single-cycle-memory controller. Adds a memory ready handshake with wait states and a watchdog timeout, JALR, LUI/AUIPC, and an illegal-opcode trap. It drives the same datapath select and strobe signals, and sits between the instruction register opcode field and the datapath/memory interface.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `WAIT_MAX`, default 16: maximum wait cycles per memory access before timeout; 0 disables the watchdog.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode field of the instruction register.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access in progress.
- `branch`, `pc_update`, `reg_write`, `mem_write`, `ir_write`, `adr_src`  out  1 each  datapath strobes/selects.
- `result_src`, `alu_srcA`, `alu_srcB`, `alu_op`  out  2 each  datapath mux selects. `alu_srcA` 11 = zero.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `mem_timeout`  out  1  one-cycle pulse on a watchdog expiry.
- `state_dbg`  out  5  current state encoding.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR_PC, JALR_LINK, LUI, AUIPC, TRAP.
- Output encodings per state:
  - FETCH: `mem_req`=1, `adr_src`=0, `alu_srcA`=00, `alu_srcB`=10, `alu_op`=00, `result_src`=10.
  - DECODE: `alu_srcA`=01, `alu_srcB`=01.
  - MEMADR and EXECI: `alu_srcA`=10, `alu_srcB`=01. EXECI also sets `alu_op`=10.
  - EXECR: `alu_srcA`=10, `alu_srcB`=00, `alu_op`=10.
  - BRANCH: `alu_srcA`=10, `alu_srcB`=00, `alu_op`=01, `branch`=1. Covers all B-type; funct3 is resolved in the datapath.
  - JAL: `alu_srcA`=01, `alu_srcB`=10, `pc_update`=1, then goes to ALUWB.
  - MEMREAD: `mem_req`=1, `adr_src`=1.
  - MEMWRITE: `mem_req`=1, `adr_src`=1, `mem_write`=1.
  - MEMWB: `result_src`=01, `reg_write`=1.
  - ALUWB: `result_src`=00, `reg_write`=1.
  - JALR_PC: `alu_srcA`=10, `alu_srcB`=01, `result_src`=10, `pc_update`=1.
  - JALR_LINK: `alu_srcA`=01, `alu_srcB`=10, `result_src`=10, `reg_write`=1. The PC is updated before the link write, so rd==rs1 is safe.
  - LUI: `alu_srcA`=11, `alu_srcB`=01. AUIPC: `alu_srcA`=01, `alu_srcB`=01. Both go to ALUWB.
  - Any output not listed for a state is 0.
- Decode dispatch:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_PC → JALR_LINK → FETCH
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → TRAP.
- From MEMADR: lw goes to MEMREAD → MEMWB; sw goes to MEMWRITE.
- Memory states (FETCH, MEMREAD, MEMWRITE) hold until `mem_ready`=1, then advance.
  - In FETCH, `ir_write` and `pc_update` equal `mem_ready` (the only Mealy outputs).
  - In MEMWRITE, `mem_write` stays high throughout; memory commits on the `mem_ready` cycle.
- Watchdog:
  - Counter is cleared on entry to each memory state and increments on each wait cycle.
  - When it reaches `WAIT_MAX` without ready, the FSM goes to TRAP with `mem_timeout`.
  - A fetch timeout does not advance the PC.
- TRAP: lasts one cycle, pulses the recorded cause (`illegal_op` or `mem_timeout`), then returns to FETCH.
- Any unreachable state encoding → FETCH.

## Timing
- Reset:
  - State = FETCH, watchdog counter = 0.
  - While `rst_n`=0, all strobes (`mem_req`, `ir_write`, `pc_update`, `reg_write`, `mem_write`, `branch`) and pulses are forced to 0.
  - Selects take their FETCH values.
  - Reset asserted mid-access aborts the access immediately; no write completes.
- Cycle counts with zero wait: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 4, lui/auipc 4. Each wait cycle adds one.
- If `mem_ready` arrives on the same cycle the counter reaches `WAIT_MAX`, ready wins and the access completes.
- `MEM_HANDSHAKE`=0 gives zero-wait timing, and the watchdog is inert.

## Configuration
- Macro: `MULTICYCLE_CTRL_FSM_UTYPE_EN`.
- Defined: LUI and AUIPC states exist and are dispatched.
- Undefined: the LUI and AUIPC states are compiled out; opcodes 0110111 and 0010111 go to TRAP with `illegal_op`.

## Structure
- Shared package `ctrl_fsm_pkg` holds:
  - state encoding constants (5-bit);
  - opcode constants;
  - `alu_srcA`, `alu_srcB`, `result_src` and `alu_op` encodings.
- Sub-module `mem_wait_timer`: clear/enable/expire counter, width `$clog2(WAIT_MAX+1)`, with the `WAIT_MAX`=0 disable.

## Test plan
- Reset held for 3 cycles, then lw with `mem_ready` tied high → FETCH, DECODE, MEMADR, MEMREAD, MEMWB, with `reg_write`=1 only in cycle 5 and `result_src`=01.
- sw with `mem_ready` low for 3 cycles in MEMWRITE → `mem_write` high for 4 cycles, FSM returns to FETCH after the ready cycle.
- Fetch with `mem_ready` never high, `WAIT_MAX`=16 → after 16 wait cycles, one-cycle `mem_timeout` pulse, FETCH re-entered, `pc_update` never asserted.
- Opcode 0000000 → TRAP with one `illegal_op` pulse; no `reg_write` or `mem_write`; back in FETCH 3 cycles after fetch completes.
- jalr → JALR_PC with `pc_update`=1, then JALR_LINK with `reg_write`=1 and `alu_srcA`=01, `alu_srcB`=10.
- lui built with and without `MULTICYCLE_CTRL_FSM_UTYPE_EN` → ALUWB write with `alu_srcA`=11 versus `illegal_op` pulse.

Source files
------------

// File: rtl/ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_fsm_pkg
// Shared definitions for the multi-cycle RV32I main control FSM:
//   - state encodings (5-bit, exported on state_dbg)
//   - RV32I major opcode constants
//   - datapath mux encodings (alu_srcA, alu_srcB, result_src, alu_op)
//   - trap cause encoding
// ---------------------------------------------------------------------------
package ctrl_fsm_pkg;

    typedef enum logic [4:0] {
        StFetch    = 5'd0,
        StDecode   = 5'd1,
        StMemAdr   = 5'd2,
        StMemRead  = 5'd3,
        StMemWb    = 5'd4,
        StMemWrite = 5'd5,
        StExecR    = 5'd6,
        StExecI    = 5'd7,
        StAluWb    = 5'd8,
        StBranch   = 5'd9,
        StJal      = 5'd10,
        StJalrPc   = 5'd11,
        StJalrLink = 5'd12,
        StLui      = 5'd13,
        StAuipc    = 5'd14,
        StTrap     = 5'd15
    } state_e;

    // Opcodes
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    // ALU operand A select
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Result select
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // ALU operation class
    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    typedef enum logic {
        CauseIllegal = 1'b0,
        CauseTimeout = 1'b1
    } cause_e;

    // States that drive a memory access and honour the ready handshake.
    function automatic logic is_mem_state(input state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Wait-cycle counter for the memory watchdog. Cleared by clr, advanced by en,
// and saturating at WAIT_MAX where expired is raised. WAIT_MAX = 0 disables
// the watchdog (expired is held low).
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   clr     in  synchronous clear (takes priority over en)
//   en      in  count one wait cycle
//   expired out counter has reached WAIT_MAX
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    generate
        if (WAIT_MAX == 0) begin : g_disabled
            assign expired = 1'b0;
            logic unused_in;
            assign unused_in = clr ^ en ^ clk ^ rst_n;
        end else begin : g_enabled
            logic [CntW-1:0] count_q, count_d;
            logic            at_max;

            assign at_max  = (count_q == CntW'(WAIT_MAX));
            assign expired = at_max;

            always_comb begin
                count_d = count_q;
                if (clr) begin
                    count_d = '0;
                end else if (en && !at_max) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Main control FSM for the multi-cycle RV32I core with memory ready
// handshake, watchdog timeout, JAL/JALR, optional LUI/AUIPC and an
// illegal-opcode trap.
// Optional feature macro: MULTICYCLE_CTRL_FSM_UTYPE_EN (LUI/AUIPC support;
// when undefined those opcodes trap as illegal).
// Parameters:
//   MEM_HANDSHAKE  1 = memory states wait for mem_ready, 0 = treat ready as 1
//   WAIT_MAX       wait cycles per access before timeout, 0 = no watchdog
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   op[6:0]                    opcode field of the instruction register
//   mem_ready                  memory completes the access this cycle
//   mem_req                    memory access in progress
//   branch, pc_update, reg_write, mem_write, ir_write, adr_src  strobes
//   result_src, alu_srcA, alu_srcB, alu_op                      mux selects
//   illegal_op, mem_timeout    one-cycle trap cause pulses
//   state_dbg[4:0]             current state encoding
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import ctrl_fsm_pkg::*;
#(
    parameter int          MEM_HANDSHAKE = 1,
    parameter int unsigned WAIT_MAX      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       branch,
    output logic       pc_update,
    output logic       reg_write,
    output logic       mem_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_srcA,
    output logic [1:0] alu_srcB,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [4:0] state_dbg
);

    state_e state_q, state_d;
    cause_e cause_q, cause_d;
    logic   ready_eff;
    logic   wd_expired;
    logic   wd_clr;
    logic   wd_en;

    // Raw (ungated) strobes; reset forces them low below.
    logic mem_req_c, branch_c, pc_update_c, reg_write_c, mem_write_c, ir_write_c;
    logic illegal_c, timeout_c;

    assign ready_eff = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // Clearing on every state change covers "cleared on entry" for all memory states.
    assign wd_clr = (state_d != state_q);
    assign wd_en  = is_mem_state(state_q) && !ready_eff;

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Next state
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            StFetch, StMemRead, StMemWrite: begin
                if (ready_eff) begin
                    case (state_q)
                        StFetch:   state_d = StDecode;
                        StMemRead: state_d = StMemWb;
                        default:   state_d = StFetch;
                    endcase
                end else if (wd_expired) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end
            end
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalrPc;
`ifdef MULTICYCLE_CTRL_FSM_UTYPE_EN
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
`else
                    OpLui, OpAuipc: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
`endif
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            StMemWb:    state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
            StJalrPc:   state_d = StJalrLink;
            StJalrLink: state_d = StFetch;
`ifdef MULTICYCLE_CTRL_FSM_UTYPE_EN
            StLui:      state_d = StAluWb;
            StAuipc:    state_d = StAluWb;
`endif
            StTrap:     state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // Outputs
    always_comb begin
        mem_req_c   = 1'b0;
        branch_c    = 1'b0;
        pc_update_c = 1'b0;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        illegal_c   = 1'b0;
        timeout_c   = 1'b0;
        adr_src     = 1'b0;
        result_src  = ResAluOut;
        alu_srcA    = SrcAPc;
        alu_srcB    = SrcBRs2;
        alu_op      = AluAdd;
        case (state_q)
            StFetch: begin
                mem_req_c   = 1'b1;
                alu_srcB    = SrcBFour;
                result_src  = ResAluResult;
                // Only Mealy outputs: IR and PC latch on the ready cycle.
                ir_write_c  = ready_eff;
                pc_update_c = ready_eff;
            end
            StDecode: begin
                alu_srcA = SrcAOldPc;
                alu_srcB = SrcBImm;
            end
            StMemAdr: begin
                alu_srcA = SrcARs1;
                alu_srcB = SrcBImm;
            end
            StMemRead: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
            end
            StMemWb: begin
                result_src  = ResData;
                reg_write_c = 1'b1;
            end
            StMemWrite: begin
                mem_req_c   = 1'b1;
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
            end
            StExecR: begin
                alu_srcA = SrcARs1;
                alu_srcB = SrcBRs2;
                alu_op   = AluFunct;
            end
            StExecI: begin
                alu_srcA = SrcARs1;
                alu_srcB = SrcBImm;
                alu_op   = AluFunct;
            end
            StAluWb: begin
                result_src  = ResAluOut;
                reg_write_c = 1'b1;
            end
            StBranch: begin
                alu_srcA = SrcARs1;
                alu_srcB = SrcBRs2;
                alu_op   = AluSub;
                branch_c = 1'b1;
            end
            StJal: begin
                alu_srcA    = SrcAOldPc;
                alu_srcB    = SrcBFour;
                pc_update_c = 1'b1;
            end
            StJalrPc: begin
                alu_srcA    = SrcARs1;
                alu_srcB    = SrcBImm;
                result_src  = ResAluResult;
                pc_update_c = 1'b1;
            end
            StJalrLink: begin
                // PC already redirected, so rd == rs1 cannot corrupt the target.
                alu_srcA    = SrcAOldPc;
                alu_srcB    = SrcBFour;
                result_src  = ResAluResult;
                reg_write_c = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_FSM_UTYPE_EN
            StLui: begin
                alu_srcA = SrcAZero;
                alu_srcB = SrcBImm;
            end
            StAuipc: begin
                alu_srcA = SrcAOldPc;
                alu_srcB = SrcBImm;
            end
`endif
            StTrap: begin
                illegal_c = (cause_q == CauseIllegal);
                timeout_c = (cause_q == CauseTimeout);
            end
            default: ;
        endcase
    end

    // Reset forces every strobe and pulse low, aborting any access in flight.
    assign mem_req     = rst_n & mem_req_c;
    assign branch      = rst_n & branch_c;
    assign pc_update   = rst_n & pc_update_c;
    assign reg_write   = rst_n & reg_write_c;
    assign mem_write   = rst_n & mem_write_c;
    assign ir_write    = rst_n & ir_write_c;
    assign illegal_op  = rst_n & illegal_c;
    assign mem_timeout = rst_n & timeout_c;
    assign state_dbg   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cause_q <= CauseIllegal;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm (WAIT_MAX = 16, handshake on).
// Expected per-cycle output vectors are queued with the stimulus and compared
// as the DUT steps through each cycle.
module tb_multicycle_ctrl_fsm;
    import ctrl_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       mem_ready;
    logic       mem_req, branch, pc_update, reg_write, mem_write, ir_write, adr_src;
    logic [1:0] result_src, alu_srcA, alu_srcB, alu_op;
    logic       illegal_op, mem_timeout;
    logic [4:0] state_dbg;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .MEM_HANDSHAKE (1),
        .WAIT_MAX      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .branch      (branch),
        .pc_update   (pc_update),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .adr_src     (adr_src),
        .result_src  (result_src),
        .alu_srcA    (alu_srcA),
        .alu_srcB    (alu_srcB),
        .alu_op      (alu_op),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state_dbg   (state_dbg)
    );

    typedef struct {
        string      tag;
        logic [6:0] op;
        logic [4:0] st;
        logic       rdy;
        logic       rst;
        logic [1:0] cause;  // 0 none, 1 illegal, 2 timeout
    } step_t;

    step_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    logic [21:0] obs;
    assign obs = {state_dbg, mem_req, branch, pc_update, reg_write, mem_write, ir_write,
                  adr_src, result_src, alu_srcA, alu_srcB, alu_op, illegal_op, mem_timeout};

    task automatic check_val(input string tag, input logic [21:0] got, input logic [21:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output table written from the state/output list.
    function automatic logic [21:0] spec_out(input logic [4:0] st, input logic rdy,
                                             input logic rst, input logic [1:0] cause);
        logic mreq, br, pcu, rw, mw, irw, adr, ill, tmo;
        logic [1:0] res, sa, sb, aop;
        {mreq, br, pcu, rw, mw, irw, adr, ill, tmo} = '0;
        {res, sa, sb, aop} = '0;
        case (st)
            5'd0:  begin mreq = 1; sb = 2'b10; res = 2'b10; irw = rdy; pcu = rdy; end
            5'd1:  begin sa = 2'b01; sb = 2'b01; end
            5'd2:  begin sa = 2'b10; sb = 2'b01; end
            5'd3:  begin mreq = 1; adr = 1; end
            5'd4:  begin res = 2'b01; rw = 1; end
            5'd5:  begin mreq = 1; adr = 1; mw = 1; end
            5'd6:  begin sa = 2'b10; aop = 2'b10; end
            5'd7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            5'd8:  begin rw = 1; end
            5'd9:  begin sa = 2'b10; aop = 2'b01; br = 1; end
            5'd10: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            5'd11: begin sa = 2'b10; sb = 2'b01; res = 2'b10; pcu = 1; end
            5'd12: begin sa = 2'b01; sb = 2'b10; res = 2'b10; rw = 1; end
            5'd13: begin sa = 2'b11; sb = 2'b01; end
            5'd14: begin sa = 2'b01; sb = 2'b01; end
            5'd15: begin ill = (cause == 2'd1); tmo = (cause == 2'd2); end
            default: ;
        endcase
        if (rst) {mreq, br, pcu, rw, mw, irw, ill, tmo} = '0;
        return {st, mreq, br, pcu, rw, mw, irw, adr, res, sa, sb, aop, ill, tmo};
    endfunction

    task automatic add(input string tag, input logic [6:0] o, input logic [4:0] st,
                       input logic rdy, input logic rst, input logic [1:0] cause);
        step_t e;
        e.tag = tag; e.op = o; e.st = st; e.rdy = rdy; e.rst = rst; e.cause = cause;
        sb_q.push_back(e);
    endtask

    // Fetch with immediate ready followed by decode.
    task automatic fd(input string tag, input logic [6:0] o);
        add({tag, "_fetch"}, o, 5'd0, 1'b1, 1'b0, 2'd0);
        add({tag, "_decode"}, o, 5'd1, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic drain();
        step_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            rst_n     = ~e.rst;
            mem_ready = e.rdy;
            op        = e.op;
            #2;
            check_val(e.tag, obs, spec_out(e.st, e.rdy, e.rst, e.cause));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        op        = 7'd0;

        // Reset held three cycles; ready high must not leak through.
        for (int i = 0; i < 3; i++) add("reset", 7'd0, 5'd0, 1'b1, 1'b1, 2'd0);

        // lw, zero wait
        fd("lw", OpLoad);
        add("lw_memadr", OpLoad, 5'd2, 1'b0, 1'b0, 2'd0);
        add("lw_memread", OpLoad, 5'd3, 1'b1, 1'b0, 2'd0);
        add("lw_memwb", OpLoad, 5'd4, 1'b0, 1'b0, 2'd0);

        // sw, three wait cycles
        fd("sw", OpStore);
        add("sw_memadr", OpStore, 5'd2, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) add("sw_wait", OpStore, 5'd5, 1'b0, 1'b0, 2'd0);
        add("sw_ready", OpStore, 5'd5, 1'b1, 1'b0, 2'd0);

        // R, I, branch, jal, jalr
        fd("r", OpRType);
        add("r_exec", OpRType, 5'd6, 1'b0, 1'b0, 2'd0);
        add("r_wb", OpRType, 5'd8, 1'b0, 1'b0, 2'd0);
        fd("i", OpIType);
        add("i_exec", OpIType, 5'd7, 1'b0, 1'b0, 2'd0);
        add("i_wb", OpIType, 5'd8, 1'b0, 1'b0, 2'd0);
        fd("beq", OpBranch);
        add("beq_branch", OpBranch, 5'd9, 1'b0, 1'b0, 2'd0);
        fd("jal", OpJal);
        add("jal_jal", OpJal, 5'd10, 1'b0, 1'b0, 2'd0);
        add("jal_wb", OpJal, 5'd8, 1'b0, 1'b0, 2'd0);
        fd("jalr", OpJalr);
        add("jalr_pc", OpJalr, 5'd11, 1'b0, 1'b0, 2'd0);
        add("jalr_link", OpJalr, 5'd12, 1'b0, 1'b0, 2'd0);

        // U-type depends on build option
        fd("lui", OpLui);
`ifdef MULTICYCLE_CTRL_FSM_UTYPE_EN
        add("lui_exec", OpLui, 5'd13, 1'b0, 1'b0, 2'd0);
        add("lui_wb", OpLui, 5'd8, 1'b0, 1'b0, 2'd0);
        fd("auipc", OpAuipc);
        add("auipc_exec", OpAuipc, 5'd14, 1'b0, 1'b0, 2'd0);
        add("auipc_wb", OpAuipc, 5'd8, 1'b0, 1'b0, 2'd0);
`else
        add("lui_trap", OpLui, 5'd15, 1'b0, 1'b0, 2'd1);
        fd("auipc", OpAuipc);
        add("auipc_trap", OpAuipc, 5'd15, 1'b0, 1'b0, 2'd1);
`endif

        // Illegal opcode
        fd("ill", 7'b0000000);
        add("ill_trap", 7'b0000000, 5'd15, 1'b0, 1'b0, 2'd1);

        // Fetch timeout: counter 0..16 over 17 unready cycles, then trap
        for (int i = 0; i < 17; i++) add("fto_wait", OpRType, 5'd0, 1'b0, 1'b0, 2'd0);
        add("fto_trap", OpRType, 5'd15, 1'b0, 1'b0, 2'd2);

        // Ready arriving as the counter reaches the limit wins
        for (int i = 0; i < 16; i++) add("rw_wait", OpRType, 5'd0, 1'b0, 1'b0, 2'd0);
        add("rw_fetch", OpRType, 5'd0, 1'b1, 1'b0, 2'd0);
        add("rw_decode", OpRType, 5'd1, 1'b0, 1'b0, 2'd0);
        add("rw_exec", OpRType, 5'd6, 1'b0, 1'b0, 2'd0);
        add("rw_wb", OpRType, 5'd8, 1'b0, 1'b0, 2'd0);

        // lw with two read wait cycles
        fd("lww", OpLoad);
        add("lww_memadr", OpLoad, 5'd2, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 2; i++) add("lww_wait", OpLoad, 5'd3, 1'b0, 1'b0, 2'd0);
        add("lww_ready", OpLoad, 5'd3, 1'b1, 1'b0, 2'd0);
        add("lww_memwb", OpLoad, 5'd4, 1'b0, 1'b0, 2'd0);

        // Store timeout
        fd("swto", OpStore);
        add("swto_memadr", OpStore, 5'd2, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 17; i++) add("swto_wait", OpStore, 5'd5, 1'b0, 1'b0, 2'd0);
        add("swto_trap", OpStore, 5'd15, 1'b0, 1'b0, 2'd2);

        // Reset during a store aborts it
        fd("swrst", OpStore);
        add("swrst_memadr", OpStore, 5'd2, 1'b0, 1'b0, 2'd0);
        add("swrst_wait", OpStore, 5'd5, 1'b0, 1'b0, 2'd0);
        add("swrst_reset", OpStore, 5'd0, 1'b0, 1'b1, 2'd0);
        fd("post", OpRType);
        add("post_exec", OpRType, 5'd6, 1'b0, 1'b0, 2'd0);
        add("post_wb", OpRType, 5'd8, 1'b0, 1'b0, 2'd0);
        add("idle_fetch", OpRType, 5'd0, 1'b0, 1'b0, 2'd0);

        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
